// File: rtl/delaybuffer_pkg.sv
// Shared types for the STFT delay-buffer RAM.
package delaybuffer_pkg;

  // Controller state: zero-sweep in progress, or open for user traffic.
  typedef enum logic [0:0] {
    RAM_CLEAR = 1'b0,
    RAM_READY = 1'b1
  } ram_state_e;

endpackage

// File: rtl/ram_lane_array.sv
// One write-mask lane of the delay-buffer RAM: plain storage, single write
// port, registered read, no reset on either the array or the read register.
module ram_lane_array #(
  parameter int width_p  = 8,
  parameter int depth_p  = 512,
  parameter int addr_w_p = 9
) (
  input  logic                clk_i,
  input  logic                wr_en_i,
  input  logic [addr_w_p-1:0] wr_addr_i,
  input  logic [width_p-1:0]  wr_data_i,
  input  logic                rd_en_i,
  input  logic [addr_w_p-1:0] rd_addr_i,
  output logic [width_p-1:0]  rd_data_o
);

  logic [width_p-1:0] mem_q [depth_p];
  logic [width_p-1:0] rd_data_q;

  // Storage write; callers guarantee the address is in range.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read returns the pre-write contents on a same-address collision.
  always_ff @(posedge clk_i) begin
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ram_1r1w_sync_clr.sv
// 1R1W synchronous RAM with per-lane write masks, optional read-during-write
// bypass, optional output register and a hardware zero-clear sweep.
module ram_1r1w_sync_clr
  import delaybuffer_pkg::*;
#(
  parameter int width_p   = 16,
  parameter int depth_p   = 512,
  parameter int lanes_p   = 2,
  parameter int bypass_p  = 1,
  parameter int out_reg_p = 0,
  parameter int clear_p   = 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       clear_i,
  output logic                       ready_o,
  input  logic                       wr_valid_i,
  input  logic [lanes_p-1:0]         wr_mask_i,
  input  logic [$clog2(depth_p)-1:0] wr_addr_i,
  input  logic [width_p-1:0]         wr_data_i,
  input  logic                       rd_valid_i,
  input  logic [$clog2(depth_p)-1:0] rd_addr_i,
  output logic                       rd_valid_o,
  output logic [width_p-1:0]         rd_data_o
);

  localparam int lane_w_lp = width_p / lanes_p;
  localparam int addr_w_lp = $clog2(depth_p);
  localparam logic [addr_w_lp-1:0] last_addr_lp = addr_w_lp'(depth_p - 1);

  // Replace the lanes selected by sel with the freshly written data.
  function automatic logic [width_p-1:0] merge_lanes(
    input logic [width_p-1:0] stored,
    input logic [width_p-1:0] fresh,
    input logic [lanes_p-1:0] sel
  );
    logic [width_p-1:0] r;
    r = stored;
    for (int l = 0; l < lanes_p; l++) begin
      if (sel[l]) r[l*lane_w_lp +: lane_w_lp] = fresh[l*lane_w_lp +: lane_w_lp];
    end
    return r;
  endfunction

  ram_state_e           state_q, state_d;
  logic [addr_w_lp-1:0] cnt_q, cnt_d;
  logic                 ready_q, ready_d;

  logic wr_in_range, rd_in_range;
  logic wr_acc, rd_acc, clr_acc, sweep;

  assign wr_in_range = 32'(wr_addr_i) < 32'(depth_p);
  assign rd_in_range = 32'(rd_addr_i) < 32'(depth_p);
  assign wr_acc      = ready_q & wr_valid_i & wr_in_range;
  assign rd_acc      = ready_q & rd_valid_i;
  assign clr_acc     = ready_q & clear_i;
  assign sweep       = (state_q == RAM_CLEAR);
  assign ready_o     = ready_q;

  // Controller state, sweep counter and ready flag.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= (clear_p != 0) ? RAM_CLEAR : RAM_READY;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Sweep walks every address once, then opens the RAM; clear_i restarts it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    case (state_q)
      RAM_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == last_addr_lp) begin
          state_d = RAM_READY;
          cnt_d   = '0;
          ready_d = 1'b1;
        end
      end
      RAM_READY: begin
        ready_d = 1'b1;
        if (clr_acc) begin
          state_d = RAM_CLEAR;
          cnt_d   = '0;
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d = RAM_CLEAR;
        cnt_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  // Stage p0: write port muxing (sweep vs. user) and lane arrays.
  logic [addr_w_lp-1:0] lane_wr_addr;
  logic [width_p-1:0]   lane_rd;
  logic                 rd_lane_en;

  assign lane_wr_addr = sweep ? cnt_q : wr_addr_i;
  assign rd_lane_en   = rd_acc & rd_in_range;

  for (genvar l = 0; l < lanes_p; l++) begin : g_lane
    logic                 lane_we;
    logic [lane_w_lp-1:0] lane_wd;

    assign lane_we = sweep | (wr_acc & wr_mask_i[l]);
    assign lane_wd = sweep ? '0 : wr_data_i[l*lane_w_lp +: lane_w_lp];

    ram_lane_array #(
      .width_p (lane_w_lp),
      .depth_p (depth_p),
      .addr_w_p(addr_w_lp)
    ) u_lane (
      .clk_i    (clk_i),
      .wr_en_i  (lane_we),
      .wr_addr_i(lane_wr_addr),
      .wr_data_i(lane_wd),
      .rd_en_i  (rd_lane_en),
      .rd_addr_i(rd_addr_i),
      .rd_data_o(lane_rd[l*lane_w_lp +: lane_w_lp])
    );
  end

  // Lanes being written to the address being read this cycle.
  logic [lanes_p-1:0] byp_mask_d;
  assign byp_mask_d = ((bypass_p != 0) && wr_acc && (wr_addr_i == rd_addr_i)) ? wr_mask_i : '0;

  // Stage p1: bypass data and range flag captured alongside the array read.
  logic [width_p-1:0] byp_data_p1_q;
  logic [lanes_p-1:0] byp_mask_p1_q;
  logic               oor_p1_q;
  logic               vld_p1_q;
  logic [width_p-1:0] rd_data_p1;

  // Side information for the read result, loaded only on an accepted read.
  always_ff @(posedge clk_i) begin
    if (rd_acc) begin
      byp_data_p1_q <= wr_data_i;
      byp_mask_p1_q <= byp_mask_d;
      oor_p1_q      <= ~rd_in_range;
    end
  end

  // Read-valid pulse; cleared by reset so an in-flight read is dropped.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) vld_p1_q <= 1'b0;
    else         vld_p1_q <= rd_acc;
  end

  assign rd_data_p1 = oor_p1_q ? '0 : merge_lanes(lane_rd, byp_data_p1_q, byp_mask_p1_q);

  // Stage p2: optional output register, otherwise the p1 result drives the port.
  if (out_reg_p != 0) begin : g_oreg
    logic               vld_p2_q;
    logic [width_p-1:0] data_p2_q;

    // Output register holds the last read result until the next read.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        vld_p2_q  <= 1'b0;
        data_p2_q <= '0;
      end else begin
        vld_p2_q <= vld_p1_q;
        if (vld_p1_q) data_p2_q <= rd_data_p1;
      end
    end

    assign rd_valid_o = vld_p2_q;
    assign rd_data_o  = data_p2_q;
  end else begin : g_noreg
    logic data_ok_q;

    // Array read register has no reset, so mask it until a read follows reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)     data_ok_q <= 1'b0;
      else if (rd_acc) data_ok_q <= 1'b1;
    end

    assign rd_valid_o = vld_p1_q;
    assign rd_data_o  = data_ok_q ? rd_data_p1 : '0;
  end

endmodule

// File: tb/tb_ram_1r1w_sync_clr.sv
`timescale 1ns/1ps
// Bench for ram_1r1w_sync_clr: two instances share stimulus
// (A: depth 512, bypass, latency 1; B: depth 300, no bypass, latency 2).
module tb_ram_1r1w_sync_clr;

  localparam int W = 16;
  localparam int L = 2;
  localparam int AW = 9;
  localparam int DEP_A = 512;
  localparam int DEP_B = 300;

  logic          clk = 1'b0;
  logic          reset_i = 1'b0;
  logic          clear_i = 1'b0;
  logic          wr_valid_i = 1'b0;
  logic [L-1:0]  wr_mask_i = '0;
  logic [AW-1:0] wr_addr_i = '0;
  logic [W-1:0]  wr_data_i = '0;
  logic          rd_valid_i = 1'b0;
  logic [AW-1:0] rd_addr_i = '0;

  logic          a_ready, a_rv, b_ready, b_rv;
  logic [W-1:0]  a_rd, b_rd;

  always #5 clk = ~clk;

  ram_1r1w_sync_clr #(
    .width_p(W), .depth_p(DEP_A), .lanes_p(L), .bypass_p(1), .out_reg_p(0), .clear_p(1)
  ) dut_a (
    .clk_i(clk), .reset_i(reset_i), .clear_i(clear_i), .ready_o(a_ready),
    .wr_valid_i(wr_valid_i), .wr_mask_i(wr_mask_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .rd_valid_i(rd_valid_i), .rd_addr_i(rd_addr_i), .rd_valid_o(a_rv), .rd_data_o(a_rd)
  );

  ram_1r1w_sync_clr #(
    .width_p(W), .depth_p(DEP_B), .lanes_p(L), .bypass_p(0), .out_reg_p(1), .clear_p(1)
  ) dut_b (
    .clk_i(clk), .reset_i(reset_i), .clear_i(clear_i), .ready_o(b_ready),
    .wr_valid_i(wr_valid_i), .wr_mask_i(wr_mask_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .rd_valid_i(rd_valid_i), .rd_addr_i(rd_addr_i), .rd_valid_o(b_rv), .rd_data_o(b_rd)
  );

  // Reference model: word memory, remaining sweep edges, latency delay line.
  logic [W-1:0] mem [2][512];
  int           dep [2]  = '{DEP_A, DEP_B};
  bit           byp [2]  = '{1'b1, 1'b0};
  bit           oreg [2] = '{1'b0, 1'b1};
  int           clr_left [2];
  bit           s1v [2];
  bit           s2v [2];
  logic [W-1:0] s1d [2];
  logic [W-1:0] s2d [2];

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int ea, eb, st;

  function automatic logic [W-1:0] merge(input logic [W-1:0] old_w, input logic [W-1:0] new_w,
                                         input logic [L-1:0] m);
    logic [W-1:0] sel;
    sel = {{8{m[1]}}, {8{m[0]}}};
    return (old_w & ~sel) | (new_w & sel);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      clr_left[k] = dep[k];
      s1v[k] = 1'b0; s2v[k] = 1'b0;
      s1d[k] = '0;   s2d[k] = '0;
      for (int a = 0; a < 512; a++) mem[k][a] = '0;
    end
  endfunction

  function automatic void model_edge();
    bit           acc;
    logic [W-1:0] res;
    for (int k = 0; k < 2; k++) begin
      acc = 1'b0;
      res = '0;
      if (clr_left[k] > 0) begin
        clr_left[k]--;
      end else begin
        if (rd_valid_i) begin
          acc = 1'b1;
          if (rd_addr_i < dep[k]) begin
            res = mem[k][rd_addr_i];
            if (byp[k] && wr_valid_i && wr_addr_i == rd_addr_i) res = merge(res, wr_data_i, wr_mask_i);
          end
        end
        if (wr_valid_i && wr_addr_i < dep[k]) mem[k][wr_addr_i] = merge(mem[k][wr_addr_i], wr_data_i, wr_mask_i);
        if (clear_i) begin
          clr_left[k] = dep[k];
          for (int a = 0; a < 512; a++) mem[k][a] = '0;
        end
      end
      s2v[k] = s1v[k];
      if (s1v[k]) s2d[k] = s1d[k];
      s1v[k] = acc;
      if (acc) s1d[k] = res;
    end
  endfunction

  function automatic logic exp_v(input int k);
    return oreg[k] ? s2v[k] : s1v[k];
  endfunction

  function automatic logic [W-1:0] exp_d(input int k);
    return oreg[k] ? s2d[k] : s1d[k];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d actual %h required %h", nm, cyc_n, act, req);
    end
  endtask

  task automatic check_outputs();
    chk("A_ready", 32'(a_ready), 32'(clr_left[0] == 0));
    chk("B_ready", 32'(b_ready), 32'(clr_left[1] == 0));
    chk("A_rd_valid", 32'(a_rv), 32'(exp_v(0)));
    chk("B_rd_valid", 32'(b_rv), 32'(exp_v(1)));
    chk("A_rd_data", 32'(a_rd), 32'(exp_d(0)));
    chk("B_rd_data", 32'(b_rd), 32'(exp_d(1)));
  endtask

  task automatic check_zero_now(input string nm);
    chk({nm, "_A_ready"}, 32'(a_ready), 32'd0);
    chk({nm, "_B_ready"}, 32'(b_ready), 32'd0);
    chk({nm, "_A_valid"}, 32'(a_rv), 32'd0);
    chk({nm, "_B_valid"}, 32'(b_rv), 32'd0);
    chk({nm, "_A_data"}, 32'(a_rd), 32'd0);
    chk({nm, "_B_data"}, 32'(b_rd), 32'd0);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (reset_i) model_reset();
    else         model_edge();
    cyc_n++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    clear_i = 1'b0; wr_valid_i = 1'b0; rd_valid_i = 1'b0; wr_mask_i = '0;
  endtask

  task automatic rand_strobes(input bit allow_clear, input bit collide);
    wr_valid_i = 1'($urandom_range(0, 1));
    wr_mask_i  = 2'($urandom_range(0, 3));
    wr_addr_i  = collide ? 9'($urandom_range(0, 15)) : 9'($urandom_range(0, 511));
    wr_data_i  = 16'($urandom);
    rd_valid_i = 1'($urandom_range(0, 1));
    rd_addr_i  = (collide && $urandom_range(0, 1) == 1) ? wr_addr_i : 9'($urandom_range(0, 511));
    clear_i    = allow_clear ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  // Runs a sweep, recording the edge at which each ready rose and any read-valid seen before it.
  task automatic sweep_count(input bit strobes, output int ra, output int rb, output int stray);
    ra = -1; rb = -1; stray = 0;
    for (int e = 1; e <= 700 && ra < 0; e++) begin
      if (strobes && e <= DEP_B) rand_strobes(1'b1, 1'b0);
      else                       idle();
      cyc();
      if (rb < 0 && b_ready) rb = e;
      if (ra < 0 && a_ready) ra = e;
      if (rb < 0 && b_rv) stray++;
      if (ra < 0 && a_rv) stray++;
    end
    idle();
  endtask

  typedef struct {
    bit           wv;
    logic [L-1:0] m;
    logic [AW-1:0] wa;
    logic [W-1:0] wd;
    bit           rv;
    logic [AW-1:0] ra;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{1'b1, 2'b11, 9'd5,   16'hBEEF, 1'b0, 9'd0,   16'h0000, 16'h0000};
    tbl[1]  = '{1'b0, 2'b00, 9'd0,   16'h0000, 1'b1, 9'd5,   16'hBEEF, 16'hBEEF};
    tbl[2]  = '{1'b1, 2'b01, 9'd5,   16'h1234, 1'b1, 9'd5,   16'hBE34, 16'hBEEF};
    tbl[3]  = '{1'b0, 2'b00, 9'd0,   16'h0000, 1'b1, 9'd5,   16'hBE34, 16'hBE34};
    tbl[4]  = '{1'b1, 2'b11, 9'd299, 16'hA5A5, 1'b0, 9'd0,   16'h0000, 16'h0000};
    tbl[5]  = '{1'b1, 2'b11, 9'd310, 16'hDEAD, 1'b0, 9'd0,   16'h0000, 16'h0000};
    tbl[6]  = '{1'b0, 2'b00, 9'd0,   16'h0000, 1'b1, 9'd310, 16'hDEAD, 16'h0000};
    tbl[7]  = '{1'b0, 2'b00, 9'd0,   16'h0000, 1'b1, 9'd299, 16'hA5A5, 16'hA5A5};
    tbl[8]  = '{1'b1, 2'b00, 9'd7,   16'h5678, 1'b0, 9'd0,   16'h0000, 16'h0000};
    tbl[9]  = '{1'b0, 2'b00, 9'd0,   16'h0000, 1'b1, 9'd7,   16'h0000, 16'h0000};
    tbl[10] = '{1'b1, 2'b10, 9'd7,   16'hFFFF, 1'b1, 9'd7,   16'hFF00, 16'h0000};
    tbl[11] = '{1'b0, 2'b00, 9'd0,   16'h0000, 1'b1, 9'd7,   16'hFF00, 16'hFF00};

    // Reset state, asserted before any clock edge.
    model_reset();
    #1 reset_i = 1'b1;
    #1 check_zero_now("por");
    @(negedge clk);
    cyc();
    reset_i = 1'b0;

    // Power-up sweep: strobes ignored, ready at edge 512 / 300.
    sweep_count(1'b1, ea, eb, st);
    chk("por_A_ready_edge", 32'(ea), 32'(DEP_A));
    chk("por_B_ready_edge", 32'(eb), 32'(DEP_B));
    chk("por_stray_valid", 32'(st), 32'd0);

    // Freshly swept memory reads as zero.
    for (int i = 0; i < 32; i++) begin
      rd_valid_i = 1'b1;
      rd_addr_i  = 9'($urandom_range(0, 511));
      cyc();
      chk("swept_zero_A", 32'(a_rd), 32'd0);
    end
    idle();
    cyc(); cyc();

    // Directed vectors: A result one edge later, B one edge after that.
    for (int i = 0; i < 12; i++) begin
      wr_valid_i = tbl[i].wv; wr_mask_i = tbl[i].m; wr_addr_i = tbl[i].wa; wr_data_i = tbl[i].wd;
      rd_valid_i = tbl[i].rv; rd_addr_i = tbl[i].ra;
      cyc();
      chk($sformatf("vec%0d_A_valid", i), 32'(a_rv), 32'(tbl[i].rv));
      if (tbl[i].rv) chk($sformatf("vec%0d_A_data", i), 32'(a_rd), 32'(tbl[i].ea));
      idle();
      cyc();
      chk($sformatf("vec%0d_B_valid", i), 32'(b_rv), 32'(tbl[i].rv));
      if (tbl[i].rv) chk($sformatf("vec%0d_B_data", i), 32'(b_rd), 32'(tbl[i].eb));
    end

    // Randomised traffic with frequent same-address collisions.
    for (int i = 0; i < 400; i++) begin
      rand_strobes(1'b0, (i % 2) == 0);
      cyc();
    end
    idle();
    cyc(); cyc();

    // Fill, then clear with a same-cycle write and read.
    for (int a = 0; a < 512; a++) begin
      wr_valid_i = 1'b1; wr_mask_i = 2'b11; wr_addr_i = 9'(a); wr_data_i = 16'(a) ^ 16'h5A5B;
      cyc();
    end
    idle();
    clear_i = 1'b1; rd_valid_i = 1'b1; rd_addr_i = 9'd3;
    wr_valid_i = 1'b1; wr_mask_i = 2'b11; wr_addr_i = 9'd3; wr_data_i = 16'h7777;
    cyc();
    chk("clr_cycle_read_A", 32'(a_rd), 32'h7777);
    sweep_count(1'b1, ea, eb, st);
    chk("clr_A_low_edges", 32'(ea), 32'(DEP_A));
    chk("clr_B_low_edges", 32'(eb), 32'(DEP_B));
    for (int a = 0; a < 512; a++) begin
      rd_valid_i = 1'b1; rd_addr_i = 9'(a);
      cyc();
      chk("clr_zero_A", 32'(a_rd), 32'd0);
    end
    idle();
    cyc(); cyc();

    // Async reset with a read in flight.
    wr_valid_i = 1'b1; wr_mask_i = 2'b11; wr_addr_i = 9'd5; wr_data_i = 16'hC0DE;
    cyc();
    idle();
    rd_valid_i = 1'b1; rd_addr_i = 9'd5;
    @(posedge clk);
    model_edge();
    cyc_n++;
    #1;
    chk("inflight_A_valid", 32'(a_rv), 32'd1);
    chk("inflight_A_data", 32'(a_rd), 32'hC0DE);
    #1 reset_i = 1'b1;
    idle();
    model_reset();
    #1 check_zero_now("rst_inflight");
    cyc();
    reset_i = 1'b0;
    sweep_count(1'b1, ea, eb, st);
    chk("rst1_A_ready_edge", 32'(ea), 32'(DEP_A));
    chk("rst1_B_ready_edge", 32'(eb), 32'(DEP_B));
    chk("rst1_stray_valid", 32'(st), 32'd0);

    // Async reset in the middle of a requested sweep.
    wr_valid_i = 1'b1; wr_mask_i = 2'b11; wr_addr_i = 9'd5; wr_data_i = 16'h1111;
    cyc();
    idle();
    clear_i = 1'b1; rd_valid_i = 1'b1; rd_addr_i = 9'd5;
    cyc();
    idle();
    repeat (100) cyc();
    chk("midsweep_hold_A", 32'(a_rd), 32'h1111);
    #2 reset_i = 1'b1;
    model_reset();
    #1 check_zero_now("rst_midsweep");
    cyc();
    reset_i = 1'b0;
    sweep_count(1'b1, ea, eb, st);
    chk("rst2_A_ready_edge", 32'(ea), 32'(DEP_A));
    chk("rst2_B_ready_edge", 32'(eb), 32'(DEP_B));
    chk("rst2_stray_valid", 32'(st), 32'd0);
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual timeout required finish checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
